coeff_token_ctrl: RTL and testbench
===================================

COEFF_TOKEN_CTRL -- requirements
Module: coeff_token_ctrl

Interface
REQ-001 Parameter aWIDTH, default 7, coeff_token ROM address width: {TrailingOnes[1:0], TotalCoeff[4:0]}.
REQ-002 Parameter vcWIDTH, default 8, ROM word width: {length-1[3:0], code LSBs[3:0]}; all-zero word means no valid entry.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  a block token request is present.
REQ-006 in_ready  output  1  controller can accept a request.
REQ-007 total_coeff  input  5  TotalCoeff of the current block, 0..16.
REQ-008 trailing_ones  input  2  TrailingOnes of the current block, 0..3.
REQ-009 n_a, n_b  input  5 each  TotalCoeff of the left and upper neighbour blocks.
REQ-010 avail_a, avail_b  input  1 each  neighbour availability flags.
REQ-011 chroma_dc  input  1  the request is for a chroma DC block (nC = -1).
REQ-012 rom_sel  output  2  table select: 0 = nC 0..1, 1 = nC 2..3, 2 = nC 4..7, 3 = chroma DC.
REQ-013 rom_addr  output  aWIDTH  ROM address {trailing_ones, total_coeff}.
REQ-014 rom_data  input  vcWIDTH  combinational word from the selected ROM.
REQ-015 out_valid  output  1  the token is valid; held until accepted.
REQ-016 out_ready  input  1  the downstream bit packer accepts the token.
REQ-017 out_code  output  16  codeword, right-aligned and zero-extended.
REQ-018 out_len  output  5  codeword length in bits, 1..16.
REQ-019 err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-020 The FSM SHALL have four states: IDLE, CALC, LOOKUP and OUT; in_ready SHALL be 1 only in IDLE.
REQ-021 The IDLE->CALC transition SHALL occur on in_valid & in_ready, and all inputs SHALL be registered on that edge.
REQ-022 In CALC the block SHALL compute nC as follows: both neighbours available -> (n_a+n_b+1)>>1, 6-bit sum; only A -> n_a; only B -> n_b; neither -> 0. If chroma_dc is set, the computed nC SHALL be ignored.
REQ-023 In CALC the block SHALL check legality: trailing_ones>total_coeff, total_coeff>16, or (chroma_dc and total_coeff>4) -> err pulse and return to IDLE, with no output.
REQ-024 If the block is not chroma DC and nC>=8, CALC SHALL go directly to OUT with a fixed-length code: out_len=6; out_code = 6'b000011 if total_coeff=0, else {total_coeff-1[3:0], trailing_ones}.
REQ-025 In every other case, CALC->LOOKUP.
REQ-026 In LOOKUP, rom_sel and rom_addr SHALL be driven from registered values. rom_data SHALL be captured at the end of the cycle: out_len = rom_data[7:4]+1, out_code = zero-extended rom_data[3:0].
REQ-027 If the captured rom_data is 8'h00, the block SHALL raise err and go to IDLE, except for the legal entry nC 0..1, TC=0, T1=0, which gives code 1, length 1 and is not an error.
REQ-028 Latency from the accept edge to out_valid SHALL be 3 cycles for the ROM path and 2 cycles for the fixed-length path.
REQ-029 In OUT, out_valid=1 and out_code/out_len SHALL be stable until out_ready=1. OUT->IDLE on out_valid & out_ready; a new request cannot be accepted in that same cycle.
REQ-030 Outside LOOKUP, rom_sel and rom_addr SHALL hold their last value (no toggling).

Reset
REQ-031 While rst_n=0, state SHALL be IDLE, and in_ready=1 after deassertion; out_valid, err, out_code, out_len, rom_sel and rom_addr SHALL all be 0.
REQ-032 Reset asserted in any state SHALL abort the token immediately; no partial out_valid is allowed after release.

Structure
REQ-033 The shared package SHALL hold: the FSM state enum, rom_sel encodings, nC thresholds (2, 4, 8), the FLC zero-token constant 6'b000011, and the invalid-entry constant 8'h00.
REQ-034 nC derivation SHALL be a sub-module nc_calc (combinational inputs, registered in CALC). The four coeff_token ROMs stay outside and are multiplexed externally by rom_sel.

Verification
REQ-035 Request nC=0 (no neighbours available), TC=0, T1=0, ROM returns 8'h01 -> out_code=1, out_len=1, out_valid on cycle 3.
REQ-036 Request avail_a=avail_b=1, n_a=2, n_b=3 (nC=3), TC=3, T1=0 -> rom_sel=1, rom_addr=7'h03; ROM returns 8'h67 -> out_code=7, out_len=7.
REQ-037 Request n_a=9 (only A available), TC=5, T1=2 -> no ROM access, out_code=6'h12, out_len=6 on cycle 2; TC=0 -> out_code=6'h03, out_len=6.
REQ-038 Request TC=2, T1=3 -> err pulse in CALC, no out_valid, in_ready back high 2 cycles after accept.
REQ-039 Hold out_ready=0 for 5 cycles in OUT -> out_valid, out_code and out_len stable and in_ready=0 throughout; accepted on the first out_ready=1.
REQ-040 Assert rst_n=0 in LOOKUP -> all outputs 0 immediately; after release, in_ready=1 and no stale token is emitted.

Source files
------------

// File: rtl/coeff_token_ctrl_pkg.sv
// Shared types and constants for the coeff_token controller: FSM states,
// table selects, nC thresholds and the special code/ROM word values.
package coeff_token_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    LOOKUP = 2'd2,
    OUT    = 2'd3
  } state_e;

  localparam logic [1:0] ROM_SEL_NC01 = 2'd0;
  localparam logic [1:0] ROM_SEL_NC23 = 2'd1;
  localparam logic [1:0] ROM_SEL_NC47 = 2'd2;
  localparam logic [1:0] ROM_SEL_CDC  = 2'd3;

  localparam logic [4:0] NC_THR_2 = 5'd2;
  localparam logic [4:0] NC_THR_4 = 5'd4;
  localparam logic [4:0] NC_THR_8 = 5'd8;

  localparam logic [5:0] FLC_ZERO_TOKEN = 6'b000011;
  localparam logic [7:0] INVALID_ENTRY  = 8'h00;

  // Chroma DC always uses its own table regardless of the neighbour nC.
  function automatic logic [1:0] selectTable(input logic [4:0] nc, input logic cdc);
    if (cdc)                 return ROM_SEL_CDC;
    else if (nc < NC_THR_2)  return ROM_SEL_NC01;
    else if (nc < NC_THR_4)  return ROM_SEL_NC23;
    else                     return ROM_SEL_NC47;
  endfunction

endpackage

// File: rtl/coeff_token_ctrl_nc_calc.sv
// Derives the nC context from neighbour TotalCoeff counts and availability.
module nc_calc (
  input  logic       avail_a_i,
  input  logic       avail_b_i,
  input  logic [4:0] n_a_i,
  input  logic [4:0] n_b_i,
  output logic [4:0] nc_o
);

  logic [5:0] sum;

  // Rounded average uses a 6-bit sum so 31+31+1 cannot overflow.
  always_comb begin
    sum  = {1'b0, n_a_i} + {1'b0, n_b_i} + 6'd1;
    nc_o = 5'd0;
    if (avail_a_i && avail_b_i) nc_o = sum[5:1];
    else if (avail_a_i)         nc_o = n_a_i;
    else if (avail_b_i)         nc_o = n_b_i;
  end

endmodule

// File: rtl/coeff_token_ctrl.sv
// coeff_token controller: registers a block request, selects the VLC table or
// the fixed-length path, captures the external ROM word and hands the token on.
module coeff_token_ctrl
  import coeff_token_ctrl_pkg::*;
#(
  parameter int aWIDTH  = 7,
  parameter int vcWIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         total_coeff,
  input  logic [1:0]         trailing_ones,
  input  logic [4:0]         n_a,
  input  logic [4:0]         n_b,
  input  logic               avail_a,
  input  logic               avail_b,
  input  logic               chroma_dc,
  output logic [1:0]         rom_sel,
  output logic [aWIDTH-1:0]  rom_addr,
  input  logic [vcWIDTH-1:0] rom_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_code,
  output logic [4:0]         out_len,
  output logic               err
);

  state_e              state_q;
  logic [4:0]          tc_q;
  logic [1:0]          t1_q;
  logic [4:0]          na_q;
  logic [4:0]          nb_q;
  logic                avail_a_q;
  logic                avail_b_q;
  logic                cdc_q;
  logic [1:0]          rom_sel_q;
  logic [aWIDTH-1:0]   rom_addr_q;
  logic [15:0]         out_code_q;
  logic [4:0]          out_len_q;
  logic                err_q;

  logic [4:0]          nc;
  logic                illegal_d;
  logic                use_flc_d;
  logic [5:0]          flc_code_d;
  logic [1:0]          rom_sel_d;
  logic [aWIDTH-1:0]   rom_addr_d;
  logic                rom_invalid_d;
  logic [4:0]          rom_len_d;

  nc_calc u_nc_calc (
    .avail_a_i (avail_a_q),
    .avail_b_i (avail_b_q),
    .n_a_i     (na_q),
    .n_b_i     (nb_q),
    .nc_o      (nc)
  );

  always_comb begin
    illegal_d  = ({3'b000, t1_q} > tc_q) || (tc_q > 5'd16) || (cdc_q && (tc_q > 5'd4));
    use_flc_d  = !cdc_q && (nc >= NC_THR_8);
    flc_code_d = (tc_q == 5'd0) ? FLC_ZERO_TOKEN : {tc_q[3:0] - 4'd1, t1_q};
    rom_sel_d  = selectTable(nc, cdc_q);
    rom_addr_d = aWIDTH'({t1_q, tc_q});
    rom_len_d  = {1'b0, rom_data[vcWIDTH-1 -: 4]} + 5'd1;
    // An all-zero word is a real entry only for nC 0..1 with no coefficients.
    rom_invalid_d = (rom_data == vcWIDTH'(INVALID_ENTRY)) &&
                    !((rom_sel_q == ROM_SEL_NC01) && (tc_q == 5'd0) && (t1_q == 2'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tc_q       <= '0;
      t1_q       <= '0;
      na_q       <= '0;
      nb_q       <= '0;
      avail_a_q  <= 1'b0;
      avail_b_q  <= 1'b0;
      cdc_q      <= 1'b0;
      rom_sel_q  <= '0;
      rom_addr_q <= '0;
      out_code_q <= '0;
      out_len_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            tc_q      <= total_coeff;
            t1_q      <= trailing_ones;
            na_q      <= n_a;
            nb_q      <= n_b;
            avail_a_q <= avail_a;
            avail_b_q <= avail_b;
            cdc_q     <= chroma_dc;
            state_q   <= CALC;
          end
        end
        CALC: begin
          if (illegal_d) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (use_flc_d) begin
            out_code_q <= {10'd0, flc_code_d};
            out_len_q  <= 5'd6;
            state_q    <= OUT;
          end else begin
            rom_sel_q  <= rom_sel_d;
            rom_addr_q <= rom_addr_d;
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (rom_invalid_d) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (rom_data == vcWIDTH'(INVALID_ENTRY)) begin
            out_code_q <= 16'd1;
            out_len_q  <= 5'd1;
            state_q    <= OUT;
          end else begin
            out_code_q <= {12'd0, rom_data[3:0]};
            out_len_q  <= rom_len_d;
            state_q    <= OUT;
          end
        end
        OUT: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign rom_sel   = rom_sel_q;
  assign rom_addr  = rom_addr_q;
  assign out_code  = out_code_q;
  assign out_len   = out_len_q;
  assign err       = err_q;

endmodule

// File: tb/tb_coeff_token_ctrl.sv
// Directed self-checking bench for coeff_token_ctrl with hand-computed tokens.
module tb_coeff_token_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [4:0]  totalCoeff = '0;
  logic [1:0]  trailingOnes = '0;
  logic [4:0]  nA = '0;
  logic [4:0]  nB = '0;
  logic        availA = 1'b0;
  logic        availB = 1'b0;
  logic        chromaDc = 1'b0;
  logic [1:0]  romSel;
  logic [6:0]  romAddr;
  logic [7:0]  romData = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [15:0] outCode;
  logic [4:0]  outLen;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coeff_token_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (inValid),
    .in_ready      (inReady),
    .total_coeff   (totalCoeff),
    .trailing_ones (trailingOnes),
    .n_a           (nA),
    .n_b           (nB),
    .avail_a       (availA),
    .avail_b       (availB),
    .chroma_dc     (chromaDc),
    .rom_sel       (romSel),
    .rom_addr      (romAddr),
    .rom_data      (romData),
    .out_valid     (outValid),
    .out_ready     (outReady),
    .out_code      (outCode),
    .out_len       (outLen),
    .err           (err)
  );

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present one request and let the accept edge pass
  task automatic applyStimulus(input logic aA, input logic aB, input logic [4:0] na,
                               input logic [4:0] nb, input logic cdc,
                               input logic [4:0] tc, input logic [1:0] t1);
    availA = aA; availB = aB; nA = na; nB = nb;
    chromaDc = cdc; totalCoeff = tc; trailingOnes = t1;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
  endtask

  task automatic releaseToken(input string tag);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput({tag, "_idle_ready"}, 32'(inReady), 32'd1);
    checkOutput({tag, "_idle_valid"}, 32'(outValid), 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    #2;
    checkOutput("rst_valid", 32'(outValid), 32'd0);
    checkOutput("rst_err",   32'(err), 32'd0);
    checkOutput("rst_code",  32'(outCode), 32'd0);
    checkOutput("rst_len",   32'(outLen), 32'd0);
    checkOutput("rst_sel",   32'(romSel), 32'd0);
    checkOutput("rst_addr",  32'(romAddr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_ready", 32'(inReady), 32'd1);

    // nC=0, TC=0, T1=0, ROM word 01
    romData = 8'h01;
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0);
    checkOutput("t1_calc_ready", 32'(inReady), 32'd0);
    checkOutput("t1_calc_valid", 32'(outValid), 32'd0);
    tick();
    checkOutput("t1_sel",  32'(romSel), 32'd0);
    checkOutput("t1_addr", 32'(romAddr), 32'h00);
    checkOutput("t1_lookup_valid", 32'(outValid), 32'd0);
    tick();
    checkOutput("t1_valid", 32'(outValid), 32'd1);
    checkOutput("t1_code",  32'(outCode), 32'd1);
    checkOutput("t1_len",   32'(outLen), 32'd1);
    releaseToken("t1");

    // nC=(2+3+1)>>1=3, TC=3, T1=0, ROM word 67
    romData = 8'h67;
    applyStimulus(1'b1, 1'b1, 5'd2, 5'd3, 1'b0, 5'd3, 2'd0);
    tick();
    checkOutput("t2_sel",  32'(romSel), 32'd1);
    checkOutput("t2_addr", 32'(romAddr), 32'h03);
    tick();
    checkOutput("t2_valid", 32'(outValid), 32'd1);
    checkOutput("t2_code",  32'(outCode), 32'd7);
    checkOutput("t2_len",   32'(outLen), 32'd7);
    releaseToken("t2");

    // Only A with n_a=9: fixed-length, TC=5 T1=2 -> {4,2}
    romData = 8'hFF;
    applyStimulus(1'b1, 1'b0, 5'd9, 5'd0, 1'b0, 5'd5, 2'd2);
    checkOutput("t3_calc_valid", 32'(outValid), 32'd0);
    tick();
    checkOutput("t3_valid", 32'(outValid), 32'd1);
    checkOutput("t3_code",  32'(outCode), 32'h12);
    checkOutput("t3_len",   32'(outLen), 32'd6);
    checkOutput("t3_addr_hold", 32'(romAddr), 32'h03);
    checkOutput("t3_sel_hold",  32'(romSel), 32'd1);
    releaseToken("t3");

    // Fixed-length with TC=0
    applyStimulus(1'b1, 1'b0, 5'd9, 5'd0, 1'b0, 5'd0, 2'd0);
    tick();
    checkOutput("t4_valid", 32'(outValid), 32'd1);
    checkOutput("t4_code",  32'(outCode), 32'h03);
    checkOutput("t4_len",   32'(outLen), 32'd6);
    releaseToken("t4");

    // Boundary: (7+8+1)>>1 = 8 takes the fixed-length path, TC=16 T1=3 -> {15,3}
    applyStimulus(1'b1, 1'b1, 5'd7, 5'd8, 1'b0, 5'd16, 2'd3);
    tick();
    checkOutput("t5_valid", 32'(outValid), 32'd1);
    checkOutput("t5_code",  32'(outCode), 32'h3F);
    releaseToken("t5");

    // Boundary: (7+7+1)>>1 = 7 -> table 2, addr {01,00001}
    romData = 8'h35;
    applyStimulus(1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd1, 2'd1);
    tick();
    checkOutput("t6_sel",  32'(romSel), 32'd2);
    checkOutput("t6_addr", 32'(romAddr), 32'h21);
    tick();
    checkOutput("t6_code", 32'(outCode), 32'd5);
    checkOutput("t6_len",  32'(outLen), 32'd4);
    releaseToken("t6");

    // Chroma DC ignores a large nC; TC=4 T1=3
    romData = 8'h70;
    applyStimulus(1'b1, 1'b0, 5'd20, 5'd0, 1'b1, 5'd4, 2'd3);
    tick();
    checkOutput("t7_sel",  32'(romSel), 32'd3);
    checkOutput("t7_addr", 32'(romAddr), 32'h64);
    tick();
    checkOutput("t7_valid", 32'(outValid), 32'd1);
    checkOutput("t7_code",  32'(outCode), 32'd0);
    checkOutput("t7_len",   32'(outLen), 32'd8);
    releaseToken("t7");

    // Illegal: T1 > TC
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd2, 2'd3);
    checkOutput("t8_calc_err",   32'(err), 32'd0);
    checkOutput("t8_calc_ready", 32'(inReady), 32'd0);
    tick();
    checkOutput("t8_err",   32'(err), 32'd1);
    checkOutput("t8_ready", 32'(inReady), 32'd1);
    checkOutput("t8_valid", 32'(outValid), 32'd0);
    tick();
    checkOutput("t8_err_pulse", 32'(err), 32'd0);

    // Illegal: chroma DC with TC=5, and TC=17
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 2'd0);
    tick();
    checkOutput("t9_err", 32'(err), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd17, 2'd0);
    tick();
    checkOutput("t10_err", 32'(err), 32'd1);

    // Zero ROM word: legal for nC 0..1 TC=0 T1=0, error otherwise
    romData = 8'h00;
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0);
    tick();
    tick();
    checkOutput("t11_valid", 32'(outValid), 32'd1);
    checkOutput("t11_err",   32'(err), 32'd0);
    checkOutput("t11_code",  32'(outCode), 32'd1);
    checkOutput("t11_len",   32'(outLen), 32'd1);
    releaseToken("t11");
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd1, 2'd0);
    tick();
    tick();
    checkOutput("t12_err",   32'(err), 32'd1);
    checkOutput("t12_valid", 32'(outValid), 32'd0);
    checkOutput("t12_ready", 32'(inReady), 32'd1);

    // Back-pressure: hold out_ready low for 5 cycles
    applyStimulus(1'b1, 1'b0, 5'd9, 5'd0, 1'b0, 5'd5, 2'd2);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t13_hold_valid", 32'(outValid), 32'd1);
      checkOutput("t13_hold_code",  32'(outCode), 32'h12);
      checkOutput("t13_hold_len",   32'(outLen), 32'd6);
      checkOutput("t13_hold_ready", 32'(inReady), 32'd0);
      tick();
    end
    releaseToken("t13");

    // Reset while in LOOKUP aborts the token
    romData = 8'h67;
    applyStimulus(1'b1, 1'b1, 5'd2, 5'd3, 1'b0, 5'd3, 2'd0);
    tick();
    checkOutput("t14_sel_pre", 32'(romSel), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t14_valid", 32'(outValid), 32'd0);
    checkOutput("t14_err",   32'(err), 32'd0);
    checkOutput("t14_code",  32'(outCode), 32'd0);
    checkOutput("t14_len",   32'(outLen), 32'd0);
    checkOutput("t14_sel",   32'(romSel), 32'd0);
    checkOutput("t14_addr",  32'(romAddr), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t14_no_stale", 32'(outValid), 32'd0);
      checkOutput("t14_ready",    32'(inReady), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
